uart_rx: RTL and testbench

UART serial receiver for 8-bit frames: 1 start bit, 8 data bits sent LSB first, an optional even parity bit, and 1 stop bit. It is the receive-side counterpart of the UART transmitter. It sits between the board `rxd` pin and the byte-consuming logic, sharing the 50 MHz `sys_clk` domain. Baud timing is generated internally by a bit-period counter, and each bit is sampled once at its midpoint.

---
 rtl/uart_rx_if.sv | 34 +++
 rtl/uart_rx.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Serial line and received-byte signals of the UART receiver.
//                master = receiver side, slave = line driver / byte consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    modport master (
        input  rxd,
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output rx_busy
    );

    modport slave (
        output rxd,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8-bit UART receiver (1 start, 8 data LSB first, optional even
//                parity, 1 stop). Each bit is sampled once at its midpoint.
//                Optional parity bit enabled by defining UART_RX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  wire         sys_clk,
    input  wire         rst,
    uart_rx_if.master   bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] c_HALF_M1 = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] c_BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BRK    = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_rx_busy;
    logic             r_rxd_s1;
    logic             r_rxd_s;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bad;
    logic             r_parity_err;
`endif

    // Two-flop synchronizer for the asynchronous line; idle level is high
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_rxd_s1 <= 1'b1;
            r_rxd_s  <= 1'b1;
        end else begin
            r_rxd_s1 <= bus.rxd;
            r_rxd_s  <= r_rxd_s1;
        end
    end

    // Frame FSM with bit-period counter and registered outputs
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            // Pulses default low so each lasts exactly one cycle
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!r_rxd_s) begin
                        r_state   <= START;
                        r_rx_busy <= 1'b1;
                    end
                end

                START: begin
                    if (r_cnt == c_HALF_M1) begin
                        r_cnt <= '0;
                        if (!r_rxd_s) begin
                            r_state   <= DATA;
                            r_bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            r_par_bad <= 1'b0;
`endif
                        end else begin
                            // Line went back high: glitch, not a start bit
                            r_state   <= IDLE;
                            r_rx_busy <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (r_cnt == c_BIT_M1) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= r_rxd_s;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_cnt == c_BIT_M1) begin
                        r_cnt     <= '0;
                        r_par_bad <= (^r_shift) ^ r_rxd_s;
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (r_cnt == c_BIT_M1) begin
                        r_cnt     <= '0;
                        r_rx_data <= r_shift;
                        if (r_rxd_s) begin
                            r_state   <= IDLE;
                            r_rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (r_par_bad)
                                r_parity_err <= 1'b1;
                            else
                                r_rx_valid   <= 1'b1;
`else
                            r_rx_valid <= 1'b1;
`endif
                        end else begin
                            // Framing error wins over any parity result
                            r_frame_err <= 1'b1;
                            r_state     <= BRK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                BRK: begin
                    // Hold here until the line is released so a break is not
                    // decoded as a stream of zero frames
                    r_cnt <= '0;
                    if (r_rxd_s) begin
                        r_state   <= IDLE;
                        r_rx_busy <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    r_rx_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.rx_busy   = r_rx_busy;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Frames are driven bit by bit
//                on rxd; expected pulses are queued and matched as they occur.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB = 50_000_000 / 115200;   // 434 clocks per bit

    localparam int K_VALID = 0;
    localparam int K_FRAME = 1;
    localparam int K_PAR   = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    exp_t q[$];
    exp_t e_mon;
    int   kind_mon;

    uart_rx_if u_if();

    uart_rx #(
        .CLK_FREQ (50_000_000),
        .BAUD     (115200)
    ) u_dut (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (u_if.master)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        u_if.rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Full frame with correct even parity (when parity is compiled in)
    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_b);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_badpar(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~(^d));
        send_bit(1'b1);
    endtask
`endif

    task automatic drain(input string tag);
        chk(tag, q.size(), 0);
        q.delete();
    endtask

    // Scoreboard monitor: every output pulse must match the queue head
    always @(negedge clk) begin
        if (!rst && (u_if.rx_valid || u_if.frame_err || u_if.parity_err)) begin
            chk("err_exclusive", {31'd0, u_if.frame_err & u_if.parity_err}, 32'd0);
            chk("valid_with_err", {31'd0, u_if.rx_valid & (u_if.frame_err | u_if.parity_err)}, 32'd0);
            kind_mon = u_if.frame_err ? K_FRAME : (u_if.parity_err ? K_PAR : K_VALID);
            if (q.size() == 0) begin
                chk("unexpected_pulse", 32'(kind_mon + 1), 32'd0);
            end else begin
                e_mon = q.pop_front();
                chk("pulse_kind", 32'(kind_mon), 32'(e_mon.kind));
                chk("rx_data", {24'd0, u_if.rx_data}, {24'd0, e_mon.data});
            end
        end
    end

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        u_if.rxd = 1'b1;
        rst      = 1'b1;
        repeat (5) @(negedge clk);

        // Reset state
        chk("rst_rx_data",    {24'd0, u_if.rx_data}, 32'h00);
        chk("rst_rx_valid",   {31'd0, u_if.rx_valid}, 32'd0);
        chk("rst_frame_err",  {31'd0, u_if.frame_err}, 32'd0);
        chk("rst_parity_err", {31'd0, u_if.parity_err}, 32'd0);
        chk("rst_rx_busy",    {31'd0, u_if.rx_busy}, 32'd0);
        rst = 1'b0;
        repeat (CPB) @(negedge clk);

        // Good frames
        push(K_VALID, 8'h55); send_frame(8'h55, 1'b1);
        drain("drain_55");
        push(K_VALID, 8'hA3); send_frame(8'hA3, 1'b1);
        drain("drain_A3");
        chk("hold_rx_data", {24'd0, u_if.rx_data}, 32'hA3);
        repeat (CPB) @(negedge clk);

        // Start-bit glitch
        u_if.rxd = 1'b0;
        repeat (50) @(negedge clk);
        chk("glitch_busy", {31'd0, u_if.rx_busy}, 32'd1);
        repeat (50) @(negedge clk);
        u_if.rxd = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_idle", {31'd0, u_if.rx_busy}, 32'd0);
        drain("drain_glitch");
        repeat (CPB) @(negedge clk);

        // Frame error followed by a 20-bit break
        push(K_FRAME, 8'h3C); send_frame(8'h3C, 1'b0);
        repeat (20 * CPB) @(negedge clk);
        chk("break_busy", {31'd0, u_if.rx_busy}, 32'd1);
        chk("break_rx_data", {24'd0, u_if.rx_data}, 32'h3C);
        drain("drain_break");
        u_if.rxd = 1'b1;
        repeat (10) @(negedge clk);
        chk("break_release", {31'd0, u_if.rx_busy}, 32'd0);
        repeat (2 * CPB) @(negedge clk);

        // Back-to-back frames
        push(K_VALID, 8'h00);
        push(K_VALID, 8'hFF);
        push(K_VALID, 8'h81);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        drain("drain_b2b");
        repeat (CPB) @(negedge clk);

        // Reset during bit 4 of 0xF0: no partial byte may appear
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        u_if.rxd = 1'b1;
        repeat (200) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_rx_data", {24'd0, u_if.rx_data}, 32'h00);
        chk("mid_rst_busy",    {31'd0, u_if.rx_busy}, 32'd0);
        rst = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        chk("post_rst_rx_data", {24'd0, u_if.rx_data}, 32'h00);
        chk("post_rst_busy",    {31'd0, u_if.rx_busy}, 32'd0);
        drain("drain_rst");
        push(K_VALID, 8'h12); send_frame(8'h12, 1'b1);
        drain("drain_12");
        repeat (CPB) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // Even parity: good and bad parity bit on 0x07
        push(K_VALID, 8'h07); send_frame(8'h07, 1'b1);
        drain("drain_par_ok");
        push(K_PAR, 8'h07); send_frame_badpar(8'h07);
        drain("drain_par_bad");
        repeat (CPB) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
